// File: rtl/div_issue_ctrl.sv
// Issue controller for the shared iterative 64-bit divider: in-order request queue,
// special-case resolution (divide-by-zero, signed overflow), CDB broadcast and flush squash.
module div_issue_ctrl #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [63:0]      req_dividend,
  input  logic [63:0]      req_divisor,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             div_valid_in,
  input  logic             div_ready,
  output logic             div_signed,
  output logic [63:0]      div_dividend,
  output logic [63:0]      div_divisor,
  input  logic             div_valid_out,
  output logic             div_yumi,
  input  logic [63:0]      div_quotient,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [63:0]      cdb_data,
  input  logic             cdb_grant
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t r_state;
  state_t w_next;

  logic             r_q_signed   [DEPTH];
  logic [63:0]      r_q_dividend [DEPTH];
  logic [63:0]      r_q_divisor  [DEPTH];
  logic [TAG_W-1:0] r_q_tag      [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             r_squash;
  logic [TAG_W-1:0] r_cdb_tag;
  logic [63:0]      r_cdb_data;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_h_signed;
  logic [63:0]      w_h_dividend;
  logic [63:0]      w_h_divisor;
  logic [TAG_W-1:0] w_h_tag;
  logic             w_zero;
  logic             w_ovf;
  logic             w_special;
  logic [63:0]      w_spec_res;
  logic             w_issue;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign req_ready = ~w_full & ~flush;
  assign w_push    = req_valid & req_ready;

  assign w_h_signed   = r_q_signed[r_head];
  assign w_h_dividend = r_q_dividend[r_head];
  assign w_h_divisor  = r_q_divisor[r_head];
  assign w_h_tag      = r_q_tag[r_head];

  // Zero divisor wins over overflow when both match.
  assign w_zero     = (w_h_divisor == '0);
  assign w_ovf      = w_h_signed & (w_h_dividend == MIN_NEG) & (w_h_divisor == '1);
  assign w_special  = w_zero | w_ovf;
  assign w_spec_res = w_zero ? '1 : MIN_NEG;

  assign w_issue = (r_state == S_IDLE) & ~w_empty & ~flush;

  assign div_signed   = w_h_signed;
  assign div_dividend = w_h_dividend;
  assign div_divisor  = w_h_divisor;
  assign cdb_tag      = r_cdb_tag;
  assign cdb_data     = r_cdb_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          if (w_special) begin
            w_pop  = 1'b1;
            w_next = S_RESP;
          end else if (div_ready) begin
            w_pop  = 1'b1;
            w_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (div_valid_out) begin
          w_next = (r_squash | flush) ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        if (flush | cdb_grant) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    div_valid_in = 1'b0;
    div_yumi     = 1'b0;
    cdb_valid    = 1'b0;
    case (r_state)
      S_IDLE:  div_valid_in = w_issue & ~w_special;
      S_BUSY:  div_yumi     = div_valid_out;
      S_RESP:  cdb_valid    = ~flush;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset | flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_signed[r_tail]   <= req_signed;
      r_q_dividend[r_tail] <= req_dividend;
      r_q_divisor[r_tail]  <= req_divisor;
      r_q_tag[r_tail]      <= req_tag;
    end
  end

  // The divider cannot be aborted, so a flushed op is drained and its quotient dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_squash   <= 1'b0;
      r_cdb_tag  <= '0;
      r_cdb_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            if (w_special) begin
              r_cdb_tag  <= w_h_tag;
              r_cdb_data <= w_spec_res;
            end else if (div_ready) begin
              r_cdb_tag <= w_h_tag;
            end
          end
        end
        S_BUSY: begin
          if (div_valid_out) begin
            r_squash <= 1'b0;
            if (~r_squash & ~flush) begin
              r_cdb_data <= div_quotient;
            end
          end else if (flush) begin
            r_squash <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: behavioural divider, in-order result scoreboard,
// a directed vector table, multi-cycle corner sequences and a randomized phase.
module tb_div_issue_ctrl;

  localparam int TAG_W = 6;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] M100 = -64'sd100;
  localparam logic [63:0] M7   = -64'sd7;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic [63:0]      req_dividend;
  logic [63:0]      req_divisor;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             div_valid_in;
  logic             div_ready;
  logic             div_signed;
  logic [63:0]      div_dividend;
  logic [63:0]      div_divisor;
  logic             div_valid_out;
  logic             div_yumi;
  logic [63:0]      div_quotient;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [63:0]      cdb_data;
  logic             cdb_grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TAG_W), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_signed   (req_signed),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .req_tag      (req_tag),
    .flush        (flush),
    .div_valid_in (div_valid_in),
    .div_ready    (div_ready),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_valid_out(div_valid_out),
    .div_yumi     (div_yumi),
    .div_quotient (div_quotient),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_grant    (cdb_grant)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic checkb(input string nm, input logic act, input logic exp);
    check(nm, 64'(act), 64'(exp));
  endtask

  function automatic logic is_special(input logic sgn, input logic [63:0] a, input logic [63:0] b);
    return (b == 64'd0) || (sgn && a == MINV && b == '1);
  endfunction

  // Architectural result of a divide micro-op.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [63:0] a, input logic [63:0] b);
    if (b == 64'd0) return '1;
    if (sgn && a == MINV && b == '1) return MINV;
    if (sgn) return $signed(a) / $signed(b);
    return a / b;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return MINV;
      2:       return '1;
      3:       return 64'($urandom_range(0, 20));
      4:       return {$urandom(), $urandom()};
      default: return -64'($urandom_range(1, 20));
    endcase
  endfunction

  // Behavioural divider: accepts one op at a time, answers after a latency, holds until yumi.
  logic dv_en;
  logic dv_busy;
  logic dv_rand;
  int   dv_lat;
  int   dv_cnt;
  int   dv_starts = 0;
  int   dv_yumis  = 0;
  logic [63:0] dv_q;

  assign div_ready    = dv_en & ~dv_busy;
  assign div_quotient = dv_q;

  always @(posedge clk) begin
    if (reset) begin
      dv_busy       <= 1'b0;
      div_valid_out <= 1'b0;
      dv_cnt        <= 0;
      dv_q          <= '0;
    end else begin
      if (div_yumi) checkb("yumi_valid", div_valid_out, 1'b1);
      if (div_valid_out && div_yumi) begin
        div_valid_out <= 1'b0;
        dv_busy       <= 1'b0;
        dv_yumis      <= dv_yumis + 1;
      end else if (div_valid_in && div_ready) begin
        checkb("div_nonspecial", is_special(div_signed, div_dividend, div_divisor), 1'b0);
        dv_busy   <= 1'b1;
        dv_cnt    <= dv_rand ? int'($urandom_range(0, 4)) : dv_lat;
        dv_q      <= ref_div(div_signed, div_dividend, div_divisor);
        dv_starts <= dv_starts + 1;
      end else if (dv_busy && !div_valid_out) begin
        if (dv_cnt == 0) div_valid_out <= 1'b1;
        else             dv_cnt <= dv_cnt - 1;
      end
    end
  end

  // In-order scoreboard of results still owed on the CDB.
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } res_t;

  res_t             sb[$];
  logic             hold_p;
  logic [TAG_W-1:0] hold_tag;
  logic [63:0]      hold_data;

  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      hold_p <= 1'b0;
    end else begin
      if (cdb_valid && cdb_grant) begin
        if (sb.size() == 0) begin
          checkb("cdb_extra", 1'b1, 1'b0);
        end else begin
          res_t e;
          e = sb.pop_front();
          check("sb_tag", 64'(cdb_tag), 64'(e.tag));
          check("sb_data", cdb_data, e.data);
        end
      end
      if (flush) begin
        check("flush_gate", 64'({req_ready, div_valid_in, cdb_valid}), 64'd0);
        sb.delete();
      end
      if (req_valid && req_ready) begin
        sb.push_back(res_t'{req_tag, ref_div(req_signed, req_dividend, req_divisor)});
      end
      if (hold_p && !flush) begin
        checkb("hold_valid", cdb_valid, 1'b1);
        check("hold_tag", 64'(cdb_tag), 64'(hold_tag));
        check("hold_data", cdb_data, hold_data);
      end
      hold_p    <= cdb_valid & ~cdb_grant;
      hold_tag  <= cdb_tag;
      hold_data <= cdb_data;
    end
  end

  task automatic cyc();
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic push(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                      input logic [TAG_W-1:0] t);
    cyc();
    req_signed   = sgn;
    req_dividend = a;
    req_divisor  = b;
    req_tag      = t;
    req_valid    = 1'b1;
    #1;
    checkb("push_ready", req_ready, 1'b1);
  endtask

  task automatic wait_cdb(input string nm);
    int k;
    k = 0;
    do begin
      cyc();
      #1;
      k++;
    end while (!cdb_valid && k < 100);
    checkb(nm, cdb_valid, 1'b1);
  endtask

  typedef struct {
    logic             sgn;
    logic [63:0]      a;
    logic [63:0]      b;
    logic [TAG_W-1:0] tag;
    logic [63:0]      exp;
    logic             spec;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tbl [9];
    int   k;
    int   got;
    int   s0;
    logic seen;
    logic ok;
    logic first_vin;

    tbl[0] = '{1'b0, 64'd50, 64'd5, 6'd3, 64'd10, 1'b0};
    tbl[1] = '{1'b1, 64'd7, 64'd0, 6'd9, '1, 1'b1};
    tbl[2] = '{1'b1, MINV, '1, 6'd1, MINV, 1'b1};
    tbl[3] = '{1'b0, MINV, '1, 6'd2, 64'd0, 1'b0};
    tbl[4] = '{1'b0, 64'd0, 64'd0, 6'd4, '1, 1'b1};
    tbl[5] = '{1'b1, M100, M7, 6'd5, 64'd14, 1'b0};
    tbl[6] = '{1'b1, M100, 64'd7, 6'd6, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
    tbl[7] = '{1'b1, MINV, 64'd1, 6'd7, MINV, 1'b0};
    tbl[8] = '{1'b0, 64'd123456789, 64'd1000, 6'd63, 64'd123456, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_dividend = '0; req_divisor = '0;
    req_tag = '0; flush = 1'b0; cdb_grant = 1'b1; dv_en = 1'b1; dv_rand = 1'b0; dv_lat = 2;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkb("rst_ready", req_ready, 1'b1);
    checkb("rst_vin", div_valid_in, 1'b0);
    checkb("rst_yumi", div_yumi, 1'b0);
    checkb("rst_cdbv", cdb_valid, 1'b0);
    check("rst_tag", 64'(cdb_tag), 64'd0);
    check("rst_data", cdb_data, 64'd0);

    for (int i = 0; i < 9; i++) begin
      s0 = dv_starts;
      push(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].tag);
      k = 0;
      first_vin = 1'b0;
      do begin
        cyc();
        #1;
        k++;
        if (k == 1) first_vin = div_valid_in;
      end while (!cdb_valid && k < 100);
      checkb($sformatf("tbl%0d_valid", i), cdb_valid, 1'b1);
      check($sformatf("tbl%0d_tag", i), 64'(cdb_tag), 64'(tbl[i].tag));
      check($sformatf("tbl%0d_data", i), cdb_data, tbl[i].exp);
      check($sformatf("tbl%0d_divuse", i), 64'(dv_starts - s0), tbl[i].spec ? 64'd0 : 64'd1);
      if (tbl[i].spec) check($sformatf("tbl%0d_lat", i), 64'(k), 64'd2);
      else             checkb($sformatf("tbl%0d_vin", i), first_vin, 1'b1);
      cyc();
      #1;
      checkb($sformatf("tbl%0d_one", i), cdb_valid, 1'b0);
    end

    // Fill the queue while the divider refuses work.
    dv_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      req_signed = 1'b0; req_dividend = 64'(1000 + i); req_divisor = 64'd3;
      req_tag = TAG_W'(i); req_valid = 1'b1;
      #1;
      checkb("full_ready", req_ready, (i < 4));
    end
    cyc();
    req_valid = 1'b1;
    dv_en = 1'b1;
    #1;
    checkb("full_pop_ready", req_ready, 1'b0);
    checkb("full_issue", div_valid_in & div_ready, 1'b1);
    got = 0;
    k = 0;
    while (got < 4 && k < 300) begin
      cyc();
      #1;
      k++;
      if (cdb_valid) begin
        check("ord_tag", 64'(cdb_tag), 64'(got));
        check("ord_data", cdb_data, 64'((1000 + got) / 3));
        got++;
      end
    end
    check("ord_count", 64'(got), 64'd4);

    // Flush while the divider is working.
    dv_lat = 10;
    push(1'b0, 64'd77, 64'd7, 6'd11);
    s0 = dv_yumis;
    k = 0;
    while (!dv_busy && k < 20) begin
      cyc();
      #1;
      k++;
    end
    checkb("sq_busy", dv_busy, 1'b1);
    cyc();
    flush = 1'b1;
    #1;
    checkb("sq_flush_ready", req_ready, 1'b0);
    checkb("sq_no_yumi", div_yumi, 1'b0);
    push(1'b1, M100, M7, 6'd5);
    wait_cdb("sq_valid");
    check("sq_tag", 64'(cdb_tag), 64'd5);
    check("sq_data", cdb_data, 64'd14);
    check("sq_yumis", 64'(dv_yumis - s0), 64'd2);
    cyc();

    // Flush landing in the same cycle as the divider's result.
    dv_lat = 2;
    push(1'b0, 64'd500, 64'd5, 6'd12);
    k = 0;
    do begin
      cyc();
      #1;
      k++;
    end while (!(dv_busy && !div_valid_out && dv_cnt == 0) && k < 30);
    checkb("fo_arm", dv_busy, 1'b1);
    cyc();
    flush = 1'b1;
    #1;
    checkb("fo_vout_yumi", div_valid_out & div_yumi, 1'b1);
    checkb("fo_cdb", cdb_valid, 1'b0);
    seen = 1'b0;
    repeat (5) begin
      cyc();
      #1;
      seen |= cdb_valid;
    end
    checkb("fo_drop", seen, 1'b0);
    push(1'b1, 64'd7, 64'd0, 6'd13);
    cyc();
    #1;
    cyc();
    #1;
    checkb("fo_after_valid", cdb_valid, 1'b1);
    check("fo_after_tag", 64'(cdb_tag), 64'd13);
    cyc();

    // Grant withheld: result must hold and the next op must wait.
    cdb_grant = 1'b0;
    push(1'b0, 64'd90, 64'd9, 6'd20);
    push(1'b0, 64'd60, 64'd6, 6'd21);
    wait_cdb("e_valid");
    check("e_tag", 64'(cdb_tag), 64'd20);
    check("e_data", cdb_data, 64'd10);
    ok = 1'b1;
    repeat (10) begin
      cyc();
      #1;
      if (!(cdb_valid && cdb_tag == 6'd20 && cdb_data == 64'd10 && !div_valid_in)) ok = 1'b0;
    end
    checkb("e_hold", ok, 1'b1);
    cyc();
    cdb_grant = 1'b1;
    #1;
    checkb("e_grant_valid", cdb_valid, 1'b1);
    cyc();
    #1;
    checkb("e_next_issue", div_valid_in, 1'b1);
    wait_cdb("e2_valid");
    check("e2_tag", 64'(cdb_tag), 64'd21);
    check("e2_data", cdb_data, 64'd10);
    cyc();

    // Reset in the middle of operation.
    cdb_grant = 1'b0;
    push(1'b0, 64'd90, 64'd9, 6'd30);
    wait_cdb("f_pre_valid");
    push(1'b0, 64'd8, 64'd2, 6'd31);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    checkb("f_ready", req_ready, 1'b1);
    checkb("f_vin", div_valid_in, 1'b0);
    checkb("f_cdbv", cdb_valid, 1'b0);
    check("f_tag", 64'(cdb_tag), 64'd0);
    check("f_data", cdb_data, 64'd0);
    cyc();
    #1;
    checkb("f_empty", div_valid_in, 1'b0);
    cdb_grant = 1'b1;

    dv_rand = 1'b1;
    for (int n = 0; n < 800; n++) begin
      cyc();
      req_valid    = 1'($urandom_range(0, 1));
      req_signed   = 1'($urandom_range(0, 1));
      req_dividend = pick();
      req_divisor  = pick();
      req_tag      = TAG_W'($urandom());
      cdb_grant    = ($urandom_range(0, 9) < 7);
      dv_en        = ($urandom_range(0, 9) < 8);
      flush        = ($urandom_range(0, 99) < 3);
    end
    cyc();
    cdb_grant = 1'b1;
    dv_en = 1'b1;
    k = 0;
    while ((sb.size() != 0 || cdb_valid) && k < 500) begin
      cyc();
      #1;
      k++;
    end
    check("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Front-end controller that shares the single iterative 64-bit divide unit among divide micro-ops issued from the reservation stations. It buffers requests in a small in-order queue and sequences each one through the divider's valid/ready and valid/yumi handshakes. It resolves the architectural special cases (divide-by-zero, signed overflow) without occupying the divider. Each result is broadcast on the CDB with its ROB tag, and in-flight work is squashed on pipeline flush.

Parameters:
TAG_W, 6, width of the ROB tag carried with each request.
DEPTH, 4, request queue entries (power of two, >=2).

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  divide request present.
req_ready  output  1  queue can accept (= ~full & ~flush).
req_signed  input  1  signed division.
req_dividend  input  64  dividend.
req_divisor  input  64  divisor.
req_tag  input  TAG_W  ROB tag.
flush  input  1  squash all queued and in-flight ops.
div_valid_in  output  1  start divider.
div_ready  input  1  divider idle and accepting.
div_signed  output  1  to divider.
div_dividend  output  64  to divider (queue head).
div_divisor  output  64  to divider (queue head).
div_valid_out  input  1  divider quotient valid (held until yumi).
div_yumi  output  1  consume divider result.
div_quotient  input  64  divider result.
cdb_valid  output  1  result broadcast request.
cdb_tag  output  TAG_W  tag of result.
cdb_data  output  64  quotient.
cdb_grant  input  1  CDB accepted result this cycle.

Behaviour:
- Reset: queue empty, state S_IDLE, squash=0, all result regs 0. req_ready=1, div_valid_in=0, div_yumi=0, cdb_valid=0.
- Queue: circular FIFO with head/tail pointers and a count of width clog2(DEPTH)+1.
  - Enqueue on req_valid & req_ready; pop as defined below.
  - Simultaneous push and pop when not full: count unchanged.
  - Full: req_ready=0 even if a pop occurs that cycle (no bypass).
- Special detection on the head entry:
  - ZERO = divisor==0 → result all ones.
  - OVF = signed & dividend==64'h8000_0000_0000_0000 & divisor==all ones → result 64'h8000_0000_0000_0000.
  - ZERO takes priority over OVF.
- FSM:
  - S_IDLE, queue non-empty & ~flush:
    - head special: latch special result and tag, pop, → S_RESP.
    - otherwise: div_valid_in=1 (combinational, div_* driven from head). On div_ready: pop, latch tag, → S_BUSY. Otherwise hold.
  - S_BUSY: wait for div_valid_out. When high: div_yumi=1 that cycle.
    - squash=1: clear squash, → S_IDLE.
    - squash=0: latch div_quotient into cdb_data, → S_RESP.
  - S_RESP: cdb_valid = ~flush. On cdb_grant & ~flush → S_IDLE. cdb_tag and cdb_data are stable while waiting for grant.
- Flush (single cycle):
  - Queue cleared at the edge; any enqueue in the same cycle is blocked (req_ready=0).
  - S_IDLE: div_valid_in gated low that cycle.
  - S_BUSY: set squash; the divider cannot be aborted, so its result is drained and discarded.
  - S_RESP: cdb_valid low that cycle, → S_IDLE, result dropped.
  - Flush in the same cycle as div_valid_out in S_BUSY: the result is discarded (yumi asserted, no S_RESP).
- Reset mid-operation: controller returns to reset state. The divider is reset by the same signal, so no drain is needed.
- Latency:
  - Special op into empty idle queue: accepted at edge N, cdb_valid from cycle N+2.
  - Normal op: div_valid_in in cycle N+1. cdb_valid the cycle after div_valid_out&div_yumi.
- One operation outstanding at the divider at a time; results are returned in request order.

Test Plan:
- Unsigned 50/5, tag 3, CDB granted immediately → one div_valid_in pulse, then cdb_valid with cdb_data=10, cdb_tag=3 for exactly one cycle.
- Signed 7/0, tag 9 → div_valid_in never asserted; cdb_data=64'hFFFF_FFFF_FFFF_FFFF, tag 9, two cycles after acceptance.
- Signed 64'h8000_0000_0000_0000 / all ones → no divider use; cdb_data=64'h8000_0000_0000_0000. Same operands unsigned → sent to the divider.
- Five back-to-back requests with div_ready low → req_ready drops after 4 accepts; 5th held. Results later emerge in order with tags 0..3.
- Flush while in S_BUSY, then new request -100/-7 tag 5 → squashed result yumi'd with no cdb_valid. New result cdb_data=14, tag 5.
- cdb_grant held low for 10 cycles in S_RESP → cdb_valid, cdb_tag and cdb_data stable; no div_valid_in for the next queued op until the grant.
